// File: rtl/gpio_event_bridge_pkg.sv
// gpio_event_bridge_pkg: shared constants and width helpers for the GPIO event bridge
package gpio_event_bridge_pkg;
   localparam logic [15:0] COALESCE_MAX = 16'hFFFF;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
   function automatic int ch_bits(input int ch);
      return (ch > 1) ? clog2(ch) : 1;
   endfunction
endpackage

// File: rtl/gpio_bridge_fifo.sv
// gpio_bridge_fifo: synchronous first-word-fall-through FIFO for change events
module gpio_bridge_fifo
   import gpio_event_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  aclk,
   input  logic                  arstn,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   input  logic                  rd_en,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] dout
);
   localparam int AW = clog2(DEPTH);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wr_ptr, r_rd_ptr;
   assign empty = r_wr_ptr == r_rd_ptr;
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign dout  = r_mem[r_rd_ptr[AW-1:0]];
   // Pointer update; the extra MSB distinguishes full from empty
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (wr_en && !full) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (rd_en && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
   // Storage array, no reset needed since contents are qualified by the pointers
   always_ff @(posedge aclk) begin
      if (wr_en && !full) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/gpio_event_bridge.sv
// gpio_event_bridge: GPIO change detector to AXI-Stream events, plus stream-driven GPIO read registers
module gpio_event_bridge
   import gpio_event_bridge_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int CHANNELS    = 2,
   parameter int FIFO_DEPTH  = 16,
   parameter int POLL_CYCLES = 0,
   localparam int CH_BITS    = ch_bits(CHANNELS)
) (
   input  logic                      aclk,
   input  logic                      arstn,
   input  logic [CHANNELS*WIDTH-1:0] gpio_write,
   output logic [CHANNELS*WIDTH-1:0] gpio_read,
   output logic [WIDTH-1:0]          m_tdata,
   output logic [CH_BITS-1:0]        m_tuser,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   input  logic [WIDTH-1:0]          s_tdata,
   input  logic [CH_BITS-1:0]        s_tuser,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   output logic [15:0]               coalesce_count,
   output logic                      bad_chan
);
   logic [WIDTH-1:0]          r_gpio_q [CHANNELS];
   logic [WIDTH-1:0]          r_sent   [CHANNELS];
   logic [CHANNELS-1:0]       r_force, w_pending, w_changed;
   logic [CH_BITS-1:0]        r_ptr, w_grant, w_next_ptr;
   logic [31:0]               r_poll_cnt;
   logic [15:0]               r_coal;
   logic [CHANNELS*WIDTH-1:0] r_gpio_read;
   logic                      r_bad;
   logic [4:0]                w_coal_inc;
   logic                      w_found, w_push, w_full, w_empty, w_poll_tc;
   assign w_poll_tc      = (POLL_CYCLES > 0) && (r_poll_cnt == 32'(POLL_CYCLES - 1));
   assign w_push         = w_found && !w_full;
   assign w_next_ptr     = (w_grant == CH_BITS'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;
   assign m_tvalid       = !w_empty;
   assign s_tready       = 1'b1;
   assign gpio_read      = r_gpio_read;
   assign coalesce_count = r_coal;
   assign bad_chan       = r_bad;
   // Pending flags, upcoming input changes and the number of changes that overwrite an unsent value
   always_comb begin
      w_coal_inc = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_pending[c] = (r_gpio_q[c] != r_sent[c]) || r_force[c];
         w_changed[c] = gpio_write[c*WIDTH +: WIDTH] != r_gpio_q[c];
         w_coal_inc   = w_coal_inc + 5'(w_changed[c] && w_pending[c] && !(w_push && w_grant == CH_BITS'(c)));
      end
   end
   // Round-robin pick: the lowest offset from the pointer wins, so scan from the far end
   always_comb begin
      w_found = 1'b0;
      w_grant = r_ptr;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (w_pending[(int'(r_ptr) + i) % CHANNELS]) begin
            w_found = 1'b1;
            w_grant = CH_BITS'((int'(r_ptr) + i) % CHANNELS);
         end
      end
   end
   // Input register, last-sent values, poll forces and arbiter pointer
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_gpio_q[c] <= '0;
            r_sent[c]   <= '0;
         end
         r_force <= '0;
         r_ptr   <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_gpio_q[c] <= gpio_write[c*WIDTH +: WIDTH];
            if (w_push && w_grant == CH_BITS'(c)) r_sent[c] <= r_gpio_q[c];
            r_force[c] <= w_poll_tc || (r_force[c] && !(w_push && w_grant == CH_BITS'(c)));
         end
         if (w_push) r_ptr <= w_next_ptr;
      end
   end
   // Free-running poll counter, parked at zero when polling is disabled
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) r_poll_cnt <= '0;
      else r_poll_cnt <= (POLL_CYCLES == 0 || w_poll_tc) ? '0 : r_poll_cnt + 1'b1;
   end
   // Saturating count of overwritten pending values
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) r_coal <= '0;
      else r_coal <= (17'(r_coal) + 17'(w_coal_inc) > 17'(COALESCE_MAX)) ? COALESCE_MAX : r_coal + 16'(w_coal_inc);
   end
   // Read-update sink: valid channels load gpio_read, out-of-range channels set the sticky error
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         r_gpio_read <= '0;
         r_bad       <= 1'b0;
      end else begin
         for (int c = 0; c < CHANNELS; c++)
            if (s_tvalid && s_tuser == CH_BITS'(c)) r_gpio_read[c*WIDTH +: WIDTH] <= s_tdata;
         if (s_tvalid && 32'(s_tuser) >= 32'(CHANNELS)) r_bad <= 1'b1;
      end
   end
   gpio_bridge_fifo #(.DATA_WIDTH(CH_BITS + WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .aclk  (aclk),
      .arstn (arstn),
      .wr_en (w_push),
      .din   ({w_grant, r_gpio_q[w_grant]}),
      .full  (w_full),
      .rd_en (m_tvalid && m_tready),
      .empty (w_empty),
      .dout  ({m_tuser, m_tdata})
   );
endmodule

// File: tb/tb_gpio_event_bridge.sv
// tb_gpio_event_bridge: directed vectors and corner-case sequences for gpio_event_bridge
module tb_gpio_event_bridge;
   logic aclk = 1'b0;
   always #5 aclk = ~aclk;
   int tests = 0;
   int failed = 0;
   // Instance A: 2 x 32-bit channels, 16-deep FIFO, no polling
   logic        a_rstn, a_tv, a_tu, a_rdy, a_su, a_sv, a_sr, a_bad;
   logic [63:0] a_gw, a_gr;
   logic [31:0] a_td, a_sd;
   logic [15:0] a_cc;
   // Instance B: 3 x 8-bit channels, 4-deep FIFO, poll every 100 cycles
   logic        b_rstn, b_tv, b_rdy, b_sv, b_sr, b_bad;
   logic [23:0] b_gw, b_gr;
   logic [7:0]  b_td, b_sd;
   logic [1:0]  b_tu, b_su;
   logic [15:0] b_cc;
   gpio_event_bridge #(.WIDTH(32), .CHANNELS(2), .FIFO_DEPTH(16), .POLL_CYCLES(0)) u_a (
      .aclk(aclk), .arstn(a_rstn), .gpio_write(a_gw), .gpio_read(a_gr),
      .m_tdata(a_td), .m_tuser(a_tu), .m_tvalid(a_tv), .m_tready(a_rdy),
      .s_tdata(a_sd), .s_tuser(a_su), .s_tvalid(a_sv), .s_tready(a_sr),
      .coalesce_count(a_cc), .bad_chan(a_bad)
   );
   gpio_event_bridge #(.WIDTH(8), .CHANNELS(3), .FIFO_DEPTH(4), .POLL_CYCLES(100)) u_b (
      .aclk(aclk), .arstn(b_rstn), .gpio_write(b_gw), .gpio_read(b_gr),
      .m_tdata(b_td), .m_tuser(b_tu), .m_tvalid(b_tv), .m_tready(b_rdy),
      .s_tdata(b_sd), .s_tuser(b_su), .s_tvalid(b_sv), .s_tready(b_sr),
      .coalesce_count(b_cc), .bad_chan(b_bad)
   );
   typedef struct {
      int unsigned gw0, gw1, rdy, sv, su, sd;
      int unsigned ev, eu, ed, er0, er1;
   } vec_t;
   vec_t vecs [16];
   logic [9:0] exp_full [7];
   task automatic step();
      @(posedge aclk);
      #1;
   endtask
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [7:0] val(input int c, input int t);
      return 8'(c * 16 + t);
   endfunction
   initial begin
      int got;
      int ev;
      vecs[0]  = '{'hA5, 0, 1, 0, 0, 0,       0, 0, 0,    0, 0};
      vecs[1]  = '{'hA5, 0, 1, 0, 0, 0,       1, 0, 'hA5, 0, 0};
      vecs[2]  = '{'hA5, 0, 1, 0, 0, 0,       0, 0, 0,    0, 0};
      vecs[3]  = '{1, 2, 1, 0, 0, 0,          0, 0, 0,    0, 0};
      vecs[4]  = '{1, 2, 1, 0, 0, 0,          1, 1, 2,    0, 0};
      vecs[5]  = '{1, 2, 1, 0, 0, 0,          1, 0, 1,    0, 0};
      vecs[6]  = '{1, 2, 1, 0, 0, 0,          0, 0, 0,    0, 0};
      vecs[7]  = '{1, 3, 1, 0, 0, 0,          0, 0, 0,    0, 0};
      vecs[8]  = '{1, 3, 1, 0, 0, 0,          1, 1, 3,    0, 0};
      vecs[9]  = '{'h10, 'h20, 1, 0, 0, 0,    0, 0, 0,    0, 0};
      vecs[10] = '{'h10, 'h20, 1, 0, 0, 0,    1, 0, 'h10, 0, 0};
      vecs[11] = '{'h10, 'h20, 1, 0, 0, 0,    1, 1, 'h20, 0, 0};
      vecs[12] = '{'h10, 'h20, 1, 0, 0, 0,    0, 0, 0,    0, 0};
      vecs[13] = '{'h10, 'h20, 1, 1, 1, 'hDEAD, 0, 0, 0,  0, 'hDEAD};
      vecs[14] = '{'h10, 'h20, 1, 1, 0, 'hBEEF, 0, 0, 0,  'hBEEF, 'hDEAD};
      vecs[15] = '{'h10, 'h20, 1, 0, 1, 'h1111, 0, 0, 0,  'hBEEF, 'hDEAD};
      exp_full = '{{2'd0, 8'h01}, {2'd1, 8'h12}, {2'd2, 8'h23}, {2'd0, 8'h04},
                   {2'd1, 8'h1C}, {2'd2, 8'h2C}, {2'd0, 8'h0C}};
      a_rstn = 1'b0; a_gw = {32'h0, 32'hA5}; a_rdy = 1'b1; a_sv = 1'b0; a_su = 1'b0; a_sd = '0;
      b_rstn = 1'b0; b_gw = '0; b_rdy = 1'b0; b_sv = 1'b0; b_su = '0; b_sd = '0;
      step();
      step();
      check("a_rst_tvalid", 64'(a_tv), 64'(0));
      check("a_rst_coalesce", 64'(a_cc), 64'(0));
      check("a_rst_bad", 64'(a_bad), 64'(0));
      check("a_rst_gpio_read", a_gr, 64'(0));
      check("a_rst_tready", 64'(a_sr), 64'(1));
      check("b_rst_tvalid", 64'(b_tv), 64'(0));
      check("b_rst_gpio_read", 64'(b_gr), 64'(0));
      a_rstn = 1'b1;
      b_rstn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a_gw  = {vecs[i].gw1, vecs[i].gw0};
         a_rdy = vecs[i].rdy[0];
         a_sv  = vecs[i].sv[0];
         a_su  = vecs[i].su[0];
         a_sd  = vecs[i].sd;
         step();
         check($sformatf("vec%0d_tvalid", i), 64'(a_tv), 64'(vecs[i].ev));
         if (vecs[i].ev != 0) begin
            check($sformatf("vec%0d_tuser", i), 64'(a_tu), 64'(vecs[i].eu));
            check($sformatf("vec%0d_tdata", i), 64'(a_td), 64'(vecs[i].ed));
         end
         check($sformatf("vec%0d_gpio_read", i), a_gr, {vecs[i].er1, vecs[i].er0});
         check($sformatf("vec%0d_bad", i), 64'(a_bad), 64'(0));
      end
      a_sv = 1'b0;
      b_sv = 1'b1; b_su = 2'd3; b_sd = 8'h12;
      step();
      check("bad_set", 64'(b_bad), 64'(1));
      check("bad_read_unchanged", 64'(b_gr), 64'(0));
      b_su = 2'd2; b_sd = 8'hAB;
      step();
      check("bad_good_read", 64'(b_gr), 64'(24'hAB0000));
      check("bad_sticky", 64'(b_bad), 64'(1));
      b_sv = 1'b0;
      step();
      check("bad_sticky2", 64'(b_bad), 64'(1));
      b_rstn = 1'b0;
      #1;
      check("bad_cleared_by_reset", 64'(b_bad), 64'(0));
      step();
      b_rstn = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         b_gw = {val(2, t), val(1, t), val(0, t)};
         step();
         if (t >= 2) begin
            check("full_tvalid", 64'(b_tv), 64'(1));
            check("full_head", 64'({b_tu, b_td}), 64'({2'd0, 8'h01}));
         end
      end
      repeat (3) begin
         step();
         check("full_hold_head", 64'({b_tv, b_tu, b_td}), 64'({1'b1, 2'd0, 8'h01}));
      end
      b_rdy = 1'b1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (b_tv) begin
            if (got < 7) check($sformatf("full_pop%0d", got), 64'({b_tu, b_td}), 64'(exp_full[got]));
            got++;
         end
         step();
      end
      check("full_pop_count", 64'(got), 64'(7));
      b_rstn = 1'b0; b_gw = '0; b_rdy = 1'b1;
      step();
      b_rstn = 1'b1;
      ev = 0;
      for (int n = 1; n <= 330; n++) begin
         step();
         if (b_tv) begin
            ev++;
            check("poll_slot", 64'(n), 64'(100 * (n / 100) + 1 + int'(b_tu)));
         end
      end
      check("poll_count", 64'(ev), 64'(9));
      a_rstn = 1'b0; a_gw = '0; a_rdy = 1'b0;
      step();
      a_rstn = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         a_gw = {32'h0, 32'(32'h100 + t)};
         step();
      end
      repeat (3) step();
      check("bp_coalesce", 64'(a_cc), 64'(3));
      check("bp_head", 64'({a_tv, a_tu, a_td}), 64'({1'b1, 1'b0, 32'h101}));
      a_rdy = 1'b1;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         if (a_tv) begin
            if (got < 17) check($sformatf("bp_pop%0d", got), 64'(a_td), 64'((got < 16) ? 32'h101 + got : 32'h114));
            got++;
         end
         step();
      end
      check("bp_pop_count", 64'(got), 64'(17));
      a_rdy = 1'b0; a_gw = {32'h0, 32'h55};
      repeat (3) step();
      check("mid_queued", 64'(a_tv), 64'(1));
      a_rstn = 1'b0;
      #1;
      check("mid_flush_tvalid", 64'(a_tv), 64'(0));
      check("mid_flush_coalesce", 64'(a_cc), 64'(0));
      a_gw = {32'h66, 32'h55};
      step();
      a_rstn = 1'b1; a_rdy = 1'b1;
      step();
      check("rel_e1", 64'(a_tv), 64'(0));
      step();
      check("rel_e2", 64'({a_tv, a_tu, a_td}), 64'({1'b1, 1'b0, 32'h55}));
      step();
      check("rel_e3", 64'({a_tv, a_tu, a_td}), 64'({1'b1, 1'b1, 32'h66}));
      step();
      check("rel_e4", 64'(a_tv), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
